// File: rtl/ccip_c0_rd_arb_pkg.sv
// rtl/ccip_c0_rd_arb_pkg.sv - shared types, widths and mdata pack/unpack helpers for the C0 read arbiter
// Contents: CL_ADDR_W (cache-line VA width), MDATA_W, t_arb_state,
//           pack_mdata / unpack_id / unpack_tag.
// mdata layout: {ID in the top id_w bits, zeros, tag in the low tag_w bits}.
package ccip_c0_rd_arb_pkg;

  localparam int CL_ADDR_W = 42;
  localparam int MDATA_W   = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } t_arb_state;

  function automatic logic [MDATA_W-1:0] pack_mdata(input logic [7:0] id,
                                                    input logic [MDATA_W-1:0] tag,
                                                    input int id_w,
                                                    input int tag_w);
    logic [MDATA_W-1:0] tag_mask;
    tag_mask = (MDATA_W'(1) << tag_w) - MDATA_W'(1);
    return (MDATA_W'(id) << (MDATA_W - id_w)) | (tag & tag_mask);
  endfunction

  function automatic logic [7:0] unpack_id(input logic [MDATA_W-1:0] mdata, input int id_w);
    return 8'(mdata >> (MDATA_W - id_w));
  endfunction

  function automatic logic [MDATA_W-1:0] unpack_tag(input logic [MDATA_W-1:0] mdata, input int tag_w);
    logic [MDATA_W-1:0] tag_mask;
    tag_mask = (MDATA_W'(1) << tag_w) - MDATA_W'(1);
    return mdata & tag_mask;
  endfunction

endpackage

// File: rtl/ccip_rr_arb.sv
// rtl/ccip_rr_arb.sv - N-way round-robin arbiter with internal rotating pointer
// Ports: clk_i, rst_ni (async active-low), req_i[N] eligible requests,
//        gnt_o[N] one-hot grant (combinational). Pointer moves past the
//        winner on a grant and holds otherwise.
module ccip_rr_arb #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               idx;

  // Scan from the pointer; first eligible requester wins.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = PTR_W'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ccip_c0_rd_arbiter.sv
// rtl/ccip_c0_rd_arbiter.sv - shares the MPF C0 read-request channel among N_REQ read engines
// Ports: pClk, SoftReset_n (async active-low); per-requester req_valid/addr/tag
//        with combinational req_ready; registered c0_req_valid/addr/mdata toward
//        MPF, gated by c0_alm_full; c0_rsp_valid/mdata/data from MPF steered back
//        as registered rsp_valid (one-hot)/rsp_tag/rsp_data; drain/drained/busy.
// Optional macro CCIP_C0_RD_ARB_STATS_EN adds stat_grants and stat_almfull_cycles.
module ccip_c0_rd_arbiter
  import ccip_c0_rd_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TAG_W   = 8,
  parameter int MAX_OUT = 64
) (
  input  logic                         pClk,
  input  logic                         SoftReset_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*CL_ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*TAG_W-1:0]       req_tag,
  output logic [N_REQ-1:0]             req_ready,
  input  logic                         c0_alm_full,
  output logic                         c0_req_valid,
  output logic [CL_ADDR_W-1:0]         c0_req_addr,
  output logic [MDATA_W-1:0]           c0_req_mdata,
  input  logic                         c0_rsp_valid,
  input  logic [MDATA_W-1:0]           c0_rsp_mdata,
  input  logic [511:0]                 c0_rsp_data,
  output logic [N_REQ-1:0]             rsp_valid,
  output logic [TAG_W-1:0]             rsp_tag,
  output logic [511:0]                 rsp_data,
  input  logic                         drain,
  output logic                         drained,
  output logic                         busy
`ifdef CCIP_C0_RD_ARB_STATS_EN
  ,
  output logic [N_REQ*32-1:0]          stat_grants,
  output logic [31:0]                  stat_almfull_cycles
`endif
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  t_arb_state         state_q;
  logic               drained_q, busy_q;
  logic [CNT_W-1:0]   out_q [N_REQ];
  logic [CNT_W-1:0]   out_d [N_REQ];
  logic               any_out_q, any_out_d;
  logic [N_REQ-1:0]   elig, gnt, rsp_hit;
  logic [CL_ADDR_W-1:0] sel_addr;
  logic [TAG_W-1:0]   sel_tag;
  logic [7:0]         sel_id, rsp_id;
  logic               c0_valid_q;
  logic [CL_ADDR_W-1:0] c0_addr_q;
  logic [MDATA_W-1:0] c0_mdata_q;
  logic [N_REQ-1:0]   rsp_valid_q;
  logic [TAG_W-1:0]   rsp_tag_q;
  logic [511:0]       rsp_data_q;

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++)
      elig[i] = req_valid[i] && (out_q[i] < CNT_W'(MAX_OUT)) && !c0_alm_full && (state_q == RUN);
  end

  ccip_rr_arb #(.N(N_REQ)) u_rr (
    .clk_i (pClk),
    .rst_ni(SoftReset_n),
    .req_i (elig),
    .gnt_o (gnt)
  );

  // Keep req_ready low while reset is held so no handshake is seen mid-reset.
  assign req_ready = gnt & {N_REQ{SoftReset_n}};

  always_comb begin
    sel_addr = '0;
    sel_tag  = '0;
    sel_id   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*CL_ADDR_W +: CL_ADDR_W];
        sel_tag  = req_tag[i*TAG_W +: TAG_W];
        sel_id   = 8'(i);
      end
    end
  end

  // A response counts only if its ID names a real requester with reads in flight.
  assign rsp_id = unpack_id(c0_rsp_mdata, ID_W);
  always_comb begin
    rsp_hit = '0;
    for (int i = 0; i < N_REQ; i++)
      rsp_hit[i] = c0_rsp_valid && (rsp_id == 8'(i)) && (out_q[i] != '0);
  end

  always_comb begin
    any_out_d = 1'b0;
    any_out_q = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      out_d[i] = out_q[i];
      if (gnt[i] && !rsp_hit[i])      out_d[i] = out_q[i] + CNT_W'(1);
      else if (!gnt[i] && rsp_hit[i]) out_d[i] = out_q[i] - CNT_W'(1);
      any_out_d = any_out_d | (out_d[i] != '0);
      any_out_q = any_out_q | (out_q[i] != '0);
    end
  end

  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      for (int i = 0; i < N_REQ; i++) out_q[i] <= '0;
      c0_valid_q  <= 1'b0;
      c0_addr_q   <= '0;
      c0_mdata_q  <= '0;
      rsp_valid_q <= '0;
      rsp_tag_q   <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) out_q[i] <= out_d[i];
      c0_valid_q  <= |gnt;
      if (|gnt) begin
        c0_addr_q  <= sel_addr;
        c0_mdata_q <= pack_mdata(sel_id, MDATA_W'(sel_tag), ID_W, TAG_W);
      end
      rsp_valid_q <= rsp_hit;
      if (|rsp_hit) begin
        rsp_tag_q  <= TAG_W'(unpack_tag(c0_rsp_mdata, TAG_W));
        rsp_data_q <= c0_rsp_data;
      end
      busy_q <= any_out_d;
    end
  end

  // Drain completes only once nothing is in flight and the output register is empty.
  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      state_q   <= RUN;
      drained_q <= 1'b0;
    end else begin
      case (state_q)
        RUN:   if (drain) state_q <= DRAIN;
        DRAIN: begin
          if (!drain) state_q <= RUN;
          else if (!any_out_q && !c0_valid_q) begin
            state_q   <= IDLE;
            drained_q <= 1'b1;
          end
        end
        IDLE:  if (!drain) begin
          state_q   <= RUN;
          drained_q <= 1'b0;
        end
        default: begin
          state_q   <= RUN;
          drained_q <= 1'b0;
        end
      endcase
    end
  end

  assign c0_req_valid = c0_valid_q;
  assign c0_req_addr  = c0_addr_q;
  assign c0_req_mdata = c0_mdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_tag      = rsp_tag_q;
  assign rsp_data     = rsp_data_q;
  assign drained      = drained_q;
  assign busy         = busy_q;

`ifdef CCIP_C0_RD_ARB_STATS_EN
  logic [31:0] stat_gr_q [N_REQ];
  logic [31:0] stat_alm_q;
  logic        stat_clr;

  assign stat_clr = (state_q == RUN) && drain;

  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      for (int i = 0; i < N_REQ; i++) stat_gr_q[i] <= '0;
      stat_alm_q <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < N_REQ; i++) stat_gr_q[i] <= '0;
      stat_alm_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (gnt[i] && (stat_gr_q[i] != '1)) stat_gr_q[i] <= stat_gr_q[i] + 32'd1;
      if (c0_alm_full && (|req_valid) && (stat_alm_q != '1)) stat_alm_q <= stat_alm_q + 32'd1;
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign stat_grants[g*32 +: 32] = stat_gr_q[g];
  end
  assign stat_almfull_cycles = stat_alm_q;
`endif

endmodule

// File: tb/tb_ccip_c0_rd_arbiter.sv
// tb/tb_ccip_c0_rd_arbiter.sv - self-checking bench for ccip_c0_rd_arbiter
module tb_ccip_c0_rd_arbiter;
  localparam int N  = 4;
  localparam int TW = 8;
  localparam int MO = 64;
  localparam int AW = 42;

  logic            pClk = 1'b0;
  logic            SoftReset_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*TW-1:0] req_tag;
  logic [N-1:0]    req_ready;
  logic            c0_alm_full;
  logic            c0_req_valid;
  logic [AW-1:0]   c0_req_addr;
  logic [15:0]     c0_req_mdata;
  logic            c0_rsp_valid;
  logic [15:0]     c0_rsp_mdata;
  logic [511:0]    c0_rsp_data;
  logic [N-1:0]    rsp_valid;
  logic [TW-1:0]   rsp_tag;
  logic [511:0]    rsp_data;
  logic            drain, drained, busy;
`ifdef CCIP_C0_RD_ARB_STATS_EN
  logic [N*32-1:0] stat_grants;
  logic [31:0]     stat_almfull_cycles;
`endif

  always #5 pClk = ~pClk;

  ccip_c0_rd_arbiter #(.N_REQ(N), .TAG_W(TW), .MAX_OUT(MO)) dut (
    .pClk(pClk), .SoftReset_n(SoftReset_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_tag(req_tag), .req_ready(req_ready),
    .c0_alm_full(c0_alm_full), .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr),
    .c0_req_mdata(c0_req_mdata), .c0_rsp_valid(c0_rsp_valid), .c0_rsp_mdata(c0_rsp_mdata),
    .c0_rsp_data(c0_rsp_data), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .drain(drain), .drained(drained), .busy(busy)
`ifdef CCIP_C0_RD_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_almfull_cycles(stat_almfull_cycles)
`endif
  );

  int vecs = 0;
  int errs = 0;

  // Reference model: plain counts per requester, a rotating start index and a mode.
  int           cnt [N];
  int           ptr;
  int           mode;            // 0 = run, 1 = drain, 2 = idle
  logic         e_c0v;
  logic [AW-1:0] e_addr;
  logic [15:0]  e_md;
  logic [N-1:0] e_rspv;
  logic [TW-1:0] e_tag;
  logic [511:0] e_data;
  logic         e_busy, e_drained;
  logic [15:0]  inflight[$];

  logic [N-1:0] last_ready, last_rspv;
  logic         last_c0v, last_busy, last_drained;
  logic [15:0]  last_md;
  logic [TW-1:0] last_tag;

  typedef struct {
    logic [N-1:0] rv;
    logic         alm;
    logic [N-1:0] exp_ready;
  } vec_t;
  vec_t tbl [18];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh2id(input logic [N-1:0] v);
    int r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    ptr = 0; mode = 0;
    e_c0v = 0; e_addr = '0; e_md = '0; e_rspv = '0; e_tag = '0; e_data = '0;
    e_busy = 0; e_drained = 0;
    inflight.delete();
  endtask

  task automatic cycle(input logic [N-1:0] rv, input logic alm, input logic drn,
                       input logic rspv, input logic [15:0] md);
    int g;
    int id;
    bit acc;
    bit all0;
    logic [N-1:0] eg;
    @(negedge pClk);
    req_valid = rv; c0_alm_full = alm; drain = drn;
    c0_rsp_valid = rspv; c0_rsp_mdata = md;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'({$urandom(), $urandom()});
    req_tag = $urandom();
    for (int w = 0; w < 16; w++) c0_rsp_data[w*32 +: 32] = $urandom();
    #3;
    g = -1;
    if (mode == 0 && !alm)
      for (int k = 0; k < N; k++) begin
        int i = (ptr + k) % N;
        if (g < 0 && rv[i] && cnt[i] < MO) g = i;
      end
    eg = (g >= 0) ? N'(1 << g) : '0;
    last_ready = req_ready; last_c0v = c0_req_valid; last_md = c0_req_mdata;
    last_rspv = rsp_valid; last_tag = rsp_tag; last_busy = busy; last_drained = drained;
    chk("req_ready", 512'(req_ready), 512'(eg));
    chk("c0_req_valid", 512'(c0_req_valid), 512'(e_c0v));
    if (e_c0v) begin
      chk("c0_req_addr", 512'(c0_req_addr), 512'(e_addr));
      chk("c0_req_mdata", 512'(c0_req_mdata), 512'(e_md));
    end
    chk("rsp_valid", 512'(rsp_valid), 512'(e_rspv));
    if (|e_rspv) begin
      chk("rsp_tag", 512'(rsp_tag), 512'(e_tag));
      chk("rsp_data", rsp_data, e_data);
    end
    chk("busy", 512'(busy), 512'(e_busy));
    chk("drained", 512'(drained), 512'(e_drained));
    // mode transition uses state before this edge
    all0 = 1;
    for (int i = 0; i < N; i++) if (cnt[i] != 0) all0 = 0;
    case (mode)
      0: if (drn) mode = 1;
      1: if (!drn) mode = 0; else if (all0 && !e_c0v) mode = 2;
      default: if (!drn) mode = 0;
    endcase
    id  = int'(md >> 14);
    acc = rspv && (id < N) && (cnt[id] > 0);
    e_c0v = (g >= 0);
    if (g >= 0) begin
      e_addr = req_addr[g*AW +: AW];
      e_md   = 16'(g << 14) | 16'(req_tag[g*TW +: TW]);
      inflight.push_back(e_md);
      cnt[g]++;
      ptr = (g + 1) % N;
    end
    e_rspv = acc ? N'(1 << id) : '0;
    if (acc) begin
      e_tag  = md[TW-1:0];
      e_data = c0_rsp_data;
      cnt[id]--;
    end
    e_busy = 0;
    for (int i = 0; i < N; i++) if (cnt[i] != 0) e_busy = 1;
    e_drained = (mode == 2);
  endtask

  task automatic do_reset();
    @(negedge pClk);
    #2;
    SoftReset_n = 0; req_valid = '0; c0_rsp_valid = 0; drain = 0; c0_alm_full = 0;
    #1;
    chk("rst_req_ready", 512'(req_ready), 512'(0));
    chk("rst_c0_req_valid", 512'(c0_req_valid), 512'(0));
    chk("rst_c0_req_mdata", 512'(c0_req_mdata), 512'(0));
    chk("rst_rsp_valid", 512'(rsp_valid), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_drained", 512'(drained), 512'(0));
    @(negedge pClk);
    @(negedge pClk);
    SoftReset_n = 1;
    model_reset();
  endtask

  initial begin
    logic [15:0] late[$];
    int n;
    logic dr;
    SoftReset_n = 0; req_valid = '0; req_addr = '0; req_tag = '0; c0_alm_full = 0;
    c0_rsp_valid = 0; c0_rsp_mdata = '0; c0_rsp_data = '0; drain = 0;
    model_reset();

    // rotation, alm_full stall, pointer hold, sparse patterns
    for (int i = 0; i < 9; i++) tbl[i] = '{4'b1111, 1'b0, 4'(1 << (i % 4))};
    for (int i = 9; i < 14; i++) tbl[i] = '{4'b1111, 1'b1, 4'b0000};
    tbl[14] = '{4'b1111, 1'b0, 4'b0010};
    tbl[15] = '{4'b1001, 1'b0, 4'b1000};
    tbl[16] = '{4'b0110, 1'b0, 4'b0010};
    tbl[17] = '{4'b0000, 1'b0, 4'b0000};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].rv, tbl[i].alm, 1'b0, 1'b0, 16'h0);
      chk("tbl_ready", 512'(last_ready), 512'(tbl[i].exp_ready));
      if (i > 0) begin
        chk("tbl_c0v", 512'(last_c0v), 512'(|tbl[i-1].exp_ready));
        if (|tbl[i-1].exp_ready)
          chk("tbl_c0_id", 512'(last_md[15:14]), 512'(oh2id(tbl[i-1].exp_ready)));
      end
    end

    // credit exhaustion on requester 2
    do_reset();
    n = 0;
    for (int i = 0; i < 64; i++) begin
      cycle(4'b0100, 1'b0, 1'b0, 1'b0, 16'h0);
      if (last_ready == 4'b0100) n++;
    end
    chk("t2_grants", 512'(n), 512'(64));
    cycle(4'b0100, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("t2_65th_ready", 512'(last_ready[2]), 512'(0));
    cycle(4'b0100, 1'b0, 1'b0, 1'b1, 16'h8005);
    chk("t2_rsp_cycle_ready", 512'(last_ready), 512'(0));
    cycle(4'b0100, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("t2_rsp_valid", 512'(last_rspv), 512'(4'b0100));
    chk("t2_rsp_tag", 512'(last_tag), 512'(8'h05));
    chk("t2_regrant", 512'(last_ready), 512'(4'b0100));

    // drain with 3 outstanding
    do_reset();
    for (int i = 0; i < 3; i++) cycle(4'b0001, 1'b0, 1'b0, 1'b0, 16'h0);
    cycle(4'b0000, 1'b0, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 1'b0, 1'b1, 1'b0, 16'h0);
      chk("t4_no_grant", 512'(last_ready), 512'(0));
      chk("t4_not_drained", 512'(last_drained), 512'(0));
    end
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 1'b0, 1'b1, 1'b1, 16'h0000);
      chk("t4_no_grant_rsp", 512'(last_ready), 512'(0));
    end
    dr = 0;
    for (int i = 0; i < 2; i++) begin
      cycle(4'b1111, 1'b0, 1'b1, 1'b0, 16'h0);
      dr = dr | last_drained;
    end
    chk("t4_drained", 512'(dr), 512'(1));
    cycle(4'b1111, 1'b0, 1'b0, 1'b0, 16'h0);
    cycle(4'b1111, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("t4_resume", 512'(last_ready), 512'(4'b0010));

    // stray response and same-cycle grant/response
    do_reset();
    cycle(4'b0000, 1'b0, 1'b0, 1'b1, 16'h4033);
    cycle(4'b0000, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("t5_stray_rsp", 512'(last_rspv), 512'(0));
    chk("t5_stray_busy", 512'(last_busy), 512'(0));
    cycle(4'b0010, 1'b0, 1'b0, 1'b0, 16'h0);
    cycle(4'b0010, 1'b0, 1'b0, 1'b1, 16'h4000);
    cycle(4'b0000, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("t5_same_cycle_busy", 512'(last_busy), 512'(1));
    chk("t5_same_cycle_rsp", 512'(last_rspv), 512'(4'b0010));
    cycle(4'b0000, 1'b0, 1'b0, 1'b1, 16'h4000);
    cycle(4'b0000, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("t5_final_busy", 512'(last_busy), 512'(0));

    // reset with 10 outstanding, then late responses
    do_reset();
    for (int i = 0; i < 10; i++) cycle(4'b1111, 1'b0, 1'b0, 1'b0, 16'h0);
    late = inflight;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(4'b0000, 1'b0, 1'b0, 1'b1, late[i]);
      if (i > 0) chk("t6_late_rsp", 512'(last_rspv), 512'(0));
    end
    cycle(4'b0000, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("t6_late_busy", 512'(last_busy), 512'(0));

    // randomized traffic against the model
    do_reset();
    dr = 0;
    for (int c = 0; c < 1500; c++) begin
      logic rv_rsp;
      logic [15:0] md;
      rv_rsp = 0; md = '0;
      if ($urandom_range(39) == 0) dr = ~dr;
      if (inflight.size() != 0 && $urandom_range(1) == 0) begin
        int k = $urandom_range(inflight.size() - 1);
        md = inflight[k];
        inflight.delete(k);
        rv_rsp = 1;
      end else if ($urandom_range(19) == 0) begin
        md = 16'($urandom());
        rv_rsp = 1;
      end
      cycle(4'($urandom()), ($urandom_range(3) == 0), dr, rv_rsp, md);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ccip_c0_rd_arbiter.md
Name: ccip_c0_rd_arbiter

Overview:
Shares the MPF afu-side C0 read-request channel among N_REQ independent read engines.
- Round-robin arbitration, gated by c0TxAlmFull and per-requester outstanding-read credits.
- Tags each request's mdata with the requester ID and steers C0 read responses back to the owner.
- Sits between the user AFU engines and the MPF afu interface; requests are virtual-address reads.

Parameters:
N_REQ, 4, number of requesters (2..8)
TAG_W, 8, requester-private tag width; TAG_W + clog2(N_REQ) <= 16
MAX_OUT, 64, max outstanding reads per requester (power of two, <= 256)

Ports:
pClk  in  1  CCI-P clock
SoftReset_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester read request valid
req_addr  in  N_REQ*42  per-requester cache-line virtual address
req_tag  in  N_REQ*TAG_W  per-requester tag
req_ready  out  N_REQ  request accepted this cycle (one-hot or zero)
c0_alm_full  in  1  afu.c0TxAlmFull
c0_req_valid  out  1  registered read request to MPF
c0_req_addr  out  42  request address
c0_req_mdata  out  16  {requester ID in bits [15:16-ID_W], zeros, tag in [TAG_W-1:0]}
c0_rsp_valid  in  1  read response valid (afu.c0Rx, read response type only)
c0_rsp_mdata  in  16  response mdata
c0_rsp_data  in  512  response line
rsp_valid  out  N_REQ  per-requester response strobe (one-hot)
rsp_tag  out  TAG_W  returned tag
rsp_data  out  512  returned line (shared bus)
drain  in  1  level; stop granting and wait for all reads to return
drained  out  1  drain complete
busy  out  1  any read outstanding

Behaviour:
- Reset: all outputs 0; RR pointer = 0; credit counters = 0; FSM = RUN.
- Grant eligibility for requester i: req_valid[i], outstanding[i] < MAX_OUT, c0_alm_full == 0, FSM == RUN.
- Arbitration: round-robin starting at pointer. On a grant to i, pointer becomes (i+1) mod N_REQ. Pointer unchanged when there is no grant.
- req_ready[i] is combinational in the grant cycle; the handshake completes when req_valid & req_ready.
- c0_req_* is registered: it appears exactly 1 cycle after the handshake and is valid for 1 cycle. With no grant, c0_req_valid = 0.
- c0_alm_full is sampled in the grant cycle. At most one request issues per cycle, which CCI-P almost-full slack tolerates.
- Credits:
  - outstanding[i] increments on grant to i.
  - outstanding[i] decrements on a response whose ID == i.
  - Simultaneous increment and decrement on the same counter leaves it unchanged.
  - Width is clog2(MAX_OUT)+1.
  - A response with ID >= N_REQ, or arriving while its counter is 0, is dropped with no strobe and no counter change.
- Response path: registered with 1-cycle latency. rsp_valid[ID] = 1, rsp_tag = mdata[TAG_W-1:0], rsp_data = c0_rsp_data. Responses arrive in request order (MPF sorts) but the block does not rely on ordering.
- busy = OR of (outstanding[i] != 0), registered.
- FSM:
  - RUN -> DRAIN when drain = 1. In DRAIN, no grants are issued and responses are still accepted.
  - DRAIN -> IDLE when all counters are 0 and no request is in the output register.
  - IDLE holds drained = 1.
  - IDLE -> RUN when drain = 0.
  - DRAIN -> RUN when drain deasserts before completion.
  - drained is registered and is 1 only in IDLE.
- Reset mid-operation clears all state immediately. In-flight responses arriving after reset release are dropped because their counters are 0.

Optional Feature:
- Macro: CCIP_C0_RD_ARB_STATS_EN.
- Defined:
  - Adds output stat_grants (N_REQ*32): per-requester saturating 32-bit grant counters.
  - Adds output stat_almfull_cycles (32): saturating count of cycles with c0_alm_full = 1 and any req_valid.
  - Both counters clear on reset and on the RUN->DRAIN transition.
- Undefined: these ports and the counters are absent. All other behaviour is identical.

Decomposition:
- Package ccip_c0_rd_arb_pkg:
  - ID_W = clog2(N_REQ)
  - t_arb_state enum {RUN, DRAIN, IDLE}
  - t_ccip_clAddr-width constant (42)
  - MDATA_W = 16
  - helper functions to pack and unpack {ID, tag} into mdata
- Sub-module ccip_rr_arb: N-way round-robin grant with pointer, reused elsewhere.

Test Plan:
1. Reset, then req_valid = 4'b1111 held for 8 cycles with alm_full = 0 -> grants rotate 0,1,2,3,0,1,2,3. c0_req_mdata[15:14] follows the same sequence. Each c0_req_valid appears 1 cycle after its req_ready.
2. N_REQ = 4, requester 2 issues 64 reads with no responses -> the 65th is not granted and req_ready[2] = 0. One response with mdata = 16'h8005 -> rsp_valid = 4'b0100 and rsp_tag = 8'h05, both 1 cycle later. Requester 2 is granted again on the next cycle.
3. alm_full = 1 for 5 cycles with all requesters valid -> no c0_req_valid during those cycles. The first grant after deassertion goes to the pointer position held before the stall.
4. 3 reads outstanding, then drain = 1 -> no further grants and drained stays 0. After the 3rd response, drained = 1 within 2 cycles. drain = 0 -> grants resume the next cycle.
5. Response with mdata ID = 1 while outstanding[1] = 0 -> no rsp_valid and counters unchanged. Grant and response to the same requester in the same cycle -> counter unchanged.
6. SoftReset_n asserted low with 10 reads outstanding -> all outputs 0 immediately and busy = 0. Late responses after reset release produce no strobe.
